multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle ARM-subset controller for Gambling_CPU.
- Sequences fetch, decode, execute, memory and writeback over one shared ALU and one unified memory.
- Drives ImmSrc to the immediate extender and all datapath mux selects and write enables.
- Holds the NZCV flag register and evaluates the condition field, so predicated instructions suppress their side effects.

Parameters:
- CNT_W, 32, width of the retired-instruction counter. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Cond  in  4  Instr[31:28].
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]: I, cmd[3:0], S/L.
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  NZCV from the ALU in the current cycle.
- PCWrite  out  1  PC register enable.
- MemWrite  out  1  memory write enable.
- RegWrite  out  1  register-file write enable.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- ALUSrcA  out  1  ALU A select: 0=RD1, 1=PC.
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ExtImm, 10=constant 4.
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- ImmSrc  out  2  immediate extender mode.
- RegSrc  out  2  register-file read-address selects.
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR.
- InstrCount  out  CNT_W  retired-instruction count (optional feature).

Behaviour:
- Reset (rst_n=0 at edge): state to FETCH, Flags to 0000. While rst_n=0, all write enables are forced to 0. rst_n low mid-instruction abandons that instruction; no partial writes.
- States and transitions:
  - FETCH -> DECODE.
  - DECODE: Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FETCH (undefined, acts as NOP).
  - MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECR, EXECI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Cycles per instruction: load 5, store 4, ALU 4, branch 3, undefined 2.
- Per-state outputs (unlisted enables 0; unlisted selects 0):
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite.
  - MEMWR: AdrSrc=1, MemWrite.
  - EXECR: ALUSrcB=00, ALU decode active.
  - EXECI: ALUSrcB=01, ALU decode active.
  - ALUWB: ResultSrc=00, RegWrite.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite.
- Gating: RegWrite, MemWrite and BRANCH's PCWrite are ANDed with CondEx. FETCH's PCWrite is unconditional.
- PC writeback: in MEMWB/ALUWB with Rd=1111, PCWrite=CondEx in addition to RegWrite.
- Selects from instruction fields: ImmSrc=Op in all states. RegSrc[0]=(Op==10), RegSrc[1]=(Op==01).
- ALU decode (EXECR/EXECI only; other states ALUControl=00):
  - cmd 0100 -> ADD.
  - cmd 0010 -> SUB.
  - cmd 0000 -> AND.
  - cmd 1100 -> ORR.
  - cmd 1010 -> SUB, CMP: RegWrite suppressed in ALUWB.
  - Other cmd -> ADD, no register or flag write.
- FlagW: FlagW[1]=S; FlagW[0]=S & (ADD|SUB|CMP).
- Flag update: on the edge ending EXECR/EXECI, Flags[3:2] take ALUFlags[3:2] if FlagW[1]&CondEx, and Flags[1:0] take ALUFlags[1:0] if FlagW[0]&CondEx.
- CondEx, evaluated combinationally from the registered Flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V.
  - GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 0.
- Condition inputs (Cond, Op, Funct, Rd) come from the IR and are stable from DECODE onward.

Optional Feature:
- Macro: CTRL_INSTR_CNT_EN.
- Defined: InstrCount increments by 1 on every transition into FETCH from any state other than reset, including condition-failed instructions. It wraps at 2^CNT_W and resets to 0.
- Undefined: InstrCount is tied to 0 and no counter flops exist.

Decomposition:
- Package ctrl_pkg:
  - state enum (FETCH..BRANCH, 4-bit);
  - ALUControl, ResultSrc and ALUSrcB localparams;
  - Cond code localparams.
- Sub-module cond_logic: holds the Flags register, CondEx evaluation and FlagW gating.
- The FSM and decoders stay in multicycle_ctrl.

Test Plan:
- Reset: rst_n=0 for 2 cycles then 1 -> first cycle FETCH with IRWrite=1, PCWrite=1; Flags=0000.
- ADDS imm (Cond=1110, Op=00, Funct=101001, ALUFlags=0100):
  - 4 cycles; ImmSrc=00 and ALUControl=00 in EXECI;
  - RegWrite=1 in ALUWB; Flags=0100 afterwards.
- LDR (Op=01, Funct[0]=1):
  - 5 cycles; ImmSrc=01; AdrSrc=1 in MEMRD;
  - ResultSrc=01 and RegWrite=1 in MEMWB.
- BEQ with Z=0 (Cond=0000, Op=10): ImmSrc=10, BRANCH has PCWrite=0. With Z=1: PCWrite=1.
- CMP (cmd 1010, S=1), equal operands (ALUFlags=0110): ALUControl=01, no RegWrite, Flags=0110.
- rst_n=0 during MEMWR -> MemWrite=0 that cycle; next cycle FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types and encodings for the multicycle ARM-subset
//               controller: FSM state enum, datapath select encodings,
//               ALU command codes and condition-field codes.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  // ALUControl encodings
  localparam logic [1:0] c_alu_add = 2'b00;
  localparam logic [1:0] c_alu_sub = 2'b01;
  localparam logic [1:0] c_alu_and = 2'b10;
  localparam logic [1:0] c_alu_orr = 2'b11;

  // ResultSrc encodings
  localparam logic [1:0] c_res_aluout    = 2'b00;
  localparam logic [1:0] c_res_data      = 2'b01;
  localparam logic [1:0] c_res_aluresult = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] c_srcb_rd2  = 2'b00;
  localparam logic [1:0] c_srcb_imm  = 2'b01;
  localparam logic [1:0] c_srcb_four = 2'b10;

  // Data-processing cmd field values
  localparam logic [3:0] c_cmd_and = 4'b0000;
  localparam logic [3:0] c_cmd_sub = 4'b0010;
  localparam logic [3:0] c_cmd_add = 4'b0100;
  localparam logic [3:0] c_cmd_cmp = 4'b1010;
  localparam logic [3:0] c_cmd_orr = 4'b1100;

  // Condition-field codes
  localparam logic [3:0] c_cond_eq = 4'b0000;
  localparam logic [3:0] c_cond_ne = 4'b0001;
  localparam logic [3:0] c_cond_cs = 4'b0010;
  localparam logic [3:0] c_cond_cc = 4'b0011;
  localparam logic [3:0] c_cond_mi = 4'b0100;
  localparam logic [3:0] c_cond_pl = 4'b0101;
  localparam logic [3:0] c_cond_vs = 4'b0110;
  localparam logic [3:0] c_cond_vc = 4'b0111;
  localparam logic [3:0] c_cond_hi = 4'b1000;
  localparam logic [3:0] c_cond_ls = 4'b1001;
  localparam logic [3:0] c_cond_ge = 4'b1010;
  localparam logic [3:0] c_cond_lt = 4'b1011;
  localparam logic [3:0] c_cond_gt = 4'b1100;
  localparam logic [3:0] c_cond_le = 4'b1101;
  localparam logic [3:0] c_cond_al = 4'b1110;
  localparam logic [3:0] c_cond_nv = 4'b1111;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
// Module      : cond_logic
// Description : NZCV flag register plus condition-field evaluation. Flag
//               writes are gated by the instruction's own condition, so a
//               failed predicate leaves the flags untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_logic
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic       flag_en,
  input  logic [1:0] flagw,
  output logic       condex,
  output logic [3:0] flags
);

  logic [3:0] r_flags;
  logic       w_n, w_z, w_c, w_v;

  assign {w_n, w_z, w_c, w_v} = r_flags;
  assign flags = r_flags;

  // Condition evaluation against the registered flags
  always_comb begin
    condex = 1'b0;
    case (cond)
      c_cond_eq: condex = w_z;
      c_cond_ne: condex = ~w_z;
      c_cond_cs: condex = w_c;
      c_cond_cc: condex = ~w_c;
      c_cond_mi: condex = w_n;
      c_cond_pl: condex = ~w_n;
      c_cond_vs: condex = w_v;
      c_cond_vc: condex = ~w_v;
      c_cond_hi: condex = w_c & ~w_z;
      c_cond_ls: condex = ~w_c | w_z;
      c_cond_ge: condex = (w_n == w_v);
      c_cond_lt: condex = (w_n != w_v);
      c_cond_gt: condex = ~w_z & (w_n == w_v);
      c_cond_le: condex = w_z | (w_n != w_v);
      c_cond_al: condex = 1'b1;
      default:   condex = 1'b0;
    endcase
  end

  // Flag register: NZ and CV halves update independently at the end of execute
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (flag_en) begin
      if (flagw[1] & condex) r_flags[3:2] <= aluflags[3:2];
      if (flagw[0] & condex) r_flags[1:0] <= aluflags[1:0];
    end
  end

endmodule : cond_logic
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle ARM-subset controller. Sequences fetch, decode,
//               execute, memory and writeback over a shared ALU and unified
//               memory; drives all datapath selects and write enables.
//               Optional retired-instruction counter: CTRL_INSTR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       Cond,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic [3:0]       ALUFlags,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic [1:0]       ALUControl,
  output logic [CNT_W-1:0] InstrCount
);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] w_cmd;
  logic       w_s;
  logic [1:0] w_alu_op;
  logic       w_cmd_wr_reg;
  logic [1:0] w_flagw_dec;
  logic       w_exec;
  logic       w_condex;
  logic [3:0] w_flags;
  logic       w_pcwrite, w_memwrite, w_regwrite, w_irwrite;

  assign w_cmd  = Funct[4:1];
  assign w_s    = Funct[0];
  assign w_exec = (r_state == EXECR) || (r_state == EXECI);

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_next;
  end

  // Next-state sequencing
  always_comb begin
    w_state_next = FETCH;
    case (r_state)
      FETCH:  w_state_next = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   w_state_next = Funct[5] ? EXECI : EXECR;
          2'b01:   w_state_next = MEMADR;
          2'b10:   w_state_next = BRANCH;
          default: w_state_next = FETCH;
        endcase
      end
      MEMADR: w_state_next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  w_state_next = MEMWB;
      MEMWB:  w_state_next = FETCH;
      MEMWR:  w_state_next = FETCH;
      EXECR:  w_state_next = ALUWB;
      EXECI:  w_state_next = ALUWB;
      ALUWB:  w_state_next = FETCH;
      BRANCH: w_state_next = FETCH;
      default: w_state_next = FETCH;
    endcase
  end

  // ALU command decode; unknown commands fall back to ADD with no side effects
  always_comb begin
    w_alu_op     = c_alu_add;
    w_cmd_wr_reg = 1'b0;
    w_flagw_dec  = 2'b00;
    case (w_cmd)
      c_cmd_add: begin w_alu_op = c_alu_add; w_cmd_wr_reg = 1'b1; w_flagw_dec = {w_s, w_s};  end
      c_cmd_sub: begin w_alu_op = c_alu_sub; w_cmd_wr_reg = 1'b1; w_flagw_dec = {w_s, w_s};  end
      c_cmd_and: begin w_alu_op = c_alu_and; w_cmd_wr_reg = 1'b1; w_flagw_dec = {w_s, 1'b0}; end
      c_cmd_orr: begin w_alu_op = c_alu_orr; w_cmd_wr_reg = 1'b1; w_flagw_dec = {w_s, 1'b0}; end
      c_cmd_cmp: begin w_alu_op = c_alu_sub; w_cmd_wr_reg = 1'b0; w_flagw_dec = {w_s, w_s};  end
      default:   begin w_alu_op = c_alu_add; w_cmd_wr_reg = 1'b0; w_flagw_dec = 2'b00;       end
    endcase
  end

  cond_logic u_cond_logic (
    .clk      (clk),
    .rst_n    (rst_n),
    .cond     (Cond),
    .aluflags (ALUFlags),
    .flag_en  (w_exec),
    .flagw    (w_exec ? w_flagw_dec : 2'b00),
    .condex   (w_condex),
    .flags    (w_flags)
  );

  // Per-state datapath controls and predicated write enables
  always_comb begin
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_irwrite  = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = c_srcb_rd2;
    ResultSrc  = c_res_aluout;
    ALUControl = c_alu_add;
    case (r_state)
      FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = c_srcb_four;
        ResultSrc = c_res_aluresult;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = c_srcb_four;
        ResultSrc = c_res_aluresult;
      end
      MEMADR: ALUSrcB = c_srcb_imm;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc  = c_res_data;
        w_regwrite = w_condex;
        w_pcwrite  = w_condex & (Rd == 4'b1111);
      end
      MEMWR: begin
        AdrSrc     = 1'b1;
        w_memwrite = w_condex;
      end
      EXECR: begin
        ALUSrcB    = c_srcb_rd2;
        ALUControl = w_alu_op;
      end
      EXECI: begin
        ALUSrcB    = c_srcb_imm;
        ALUControl = w_alu_op;
      end
      ALUWB: begin
        ResultSrc  = c_res_aluout;
        w_regwrite = w_condex & w_cmd_wr_reg;
        w_pcwrite  = w_condex & (Rd == 4'b1111);
      end
      BRANCH: begin
        ALUSrcB   = c_srcb_imm;
        ResultSrc = c_res_aluresult;
        w_pcwrite = w_condex;
      end
      default: ;
    endcase
  end

  // Reset masks every write enable so nothing partial escapes
  assign PCWrite  = w_pcwrite  & rst_n;
  assign MemWrite = w_memwrite & rst_n;
  assign RegWrite = w_regwrite & rst_n;
  assign IRWrite  = w_irwrite  & rst_n;

  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

`ifdef CTRL_INSTR_CNT_EN
  logic [CNT_W-1:0] r_instr_count;

  // Count every return to FETCH, including condition-failed instructions
  always_ff @(posedge clk) begin
    if (!rst_n)                     r_instr_count <= '0;
    else if (w_state_next == FETCH) r_instr_count <= r_instr_count + CNT_W'(1);
  end

  assign InstrCount = r_instr_count;
`else
  assign InstrCount = '0;
`endif

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. Each instruction is
//               expanded into its cycle sequence by a reference model that
//               tracks NZCV and the retired count, and every cycle's outputs
//               are compared against it. Directed cases then random ones.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int CNT_W = 32;

  // Phase names used by the reference sequence
  localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5,
                 P_XR = 6, P_XI = 7, P_AWB = 8, P_BR = 9;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       Cond;
  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic [3:0]       Rd;
  logic [3:0]       ALUFlags;
  logic             PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]       ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [CNT_W-1:0] InstrCount;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] m_flags  = 4'b0000;
  logic [31:0] m_count = 32'd0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .InstrCount(InstrCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Run one instruction; abort_at >= 0 pulls reset during that phase index
  task automatic run_instr(input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] fn, input logic [3:0] rd,
                           input logic [3:0] alf, input int abort_at);
    int         ph[$];
    logic [3:0] cmd;
    logic       s, ce, wr_ok, nz_w, cv_w;
    logic [1:0] alu;
    cmd = fn[4:1];
    s   = fn[0];
    ph  = '{P_F, P_D};
    case (op)
      2'b00: begin ph.push_back(fn[5] ? P_XI : P_XR); ph.push_back(P_AWB); end
      2'b01: begin
        ph.push_back(P_MA);
        if (fn[0]) begin ph.push_back(P_MR); ph.push_back(P_MWB); end
        else       ph.push_back(P_MW);
      end
      2'b10: ph.push_back(P_BR);
      default: ;
    endcase
    // Spec ALU table
    alu = 2'b00; wr_ok = 1'b0; nz_w = 1'b0; cv_w = 1'b0;
    if      (cmd == 4'b0100) begin alu = 2'b00; wr_ok = 1; nz_w = s; cv_w = s; end
    else if (cmd == 4'b0010) begin alu = 2'b01; wr_ok = 1; nz_w = s; cv_w = s; end
    else if (cmd == 4'b0000) begin alu = 2'b10; wr_ok = 1; nz_w = s; end
    else if (cmd == 4'b1100) begin alu = 2'b11; wr_ok = 1; nz_w = s; end
    else if (cmd == 4'b1010) begin alu = 2'b01; nz_w = s; cv_w = s; end

    Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = alf;
    for (int i = 0; i < ph.size(); i++) begin
      int p;
      p  = ph[i];
      ce = cond_holds(c, m_flags);
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_memwrite", MemWrite, 0);
        chk("abort_regwrite", RegWrite, 0);
        chk("abort_pcwrite",  PCWrite,  0);
        chk("abort_irwrite",  IRWrite,  0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_flags = 4'b0000;
        m_count = 32'd0;
        chk("abort_flags", dut.w_flags, m_flags);
        return;
      end
      #1;
      chk($sformatf("irwrite p%0d", p),  IRWrite,  (p == P_F));
      chk($sformatf("pcwrite p%0d", p),  PCWrite,
          (p == P_F) || (p == P_BR && ce) ||
          ((p == P_MWB || p == P_AWB) && ce && rd == 4'hF));
      chk($sformatf("memwrite p%0d", p), MemWrite, (p == P_MW) && ce);
      chk($sformatf("regwrite p%0d", p), RegWrite,
          (p == P_MWB && ce) || (p == P_AWB && ce && wr_ok));
      chk($sformatf("adrsrc p%0d", p),   AdrSrc,   (p == P_MR || p == P_MW));
      chk($sformatf("alusrca p%0d", p),  ALUSrcA,  (p == P_F || p == P_D));
      chk($sformatf("alusrcb p%0d", p),  ALUSrcB,
          (p == P_F || p == P_D) ? 2 : (p == P_MA || p == P_XI || p == P_BR) ? 1 : 0);
      chk($sformatf("resultsrc p%0d", p), ResultSrc,
          (p == P_F || p == P_D || p == P_BR) ? 2 : (p == P_MWB) ? 1 : 0);
      chk($sformatf("alucontrol p%0d", p), ALUControl, (p == P_XR || p == P_XI) ? alu : 2'b00);
      chk($sformatf("immsrc p%0d", p),   ImmSrc,   op);
      chk($sformatf("regsrc p%0d", p),   RegSrc,   {op == 2'b01, op == 2'b10});
`ifdef CTRL_INSTR_CNT_EN
      chk($sformatf("instrcount p%0d", p), InstrCount, m_count);
`else
      chk($sformatf("instrcount p%0d", p), InstrCount, 0);
`endif
      @(posedge clk); #1;
      if ((p == P_XR || p == P_XI) && ce) begin
        if (nz_w) m_flags[3:2] = alf[3:2];
        if (cv_w) m_flags[1:0] = alf[1:0];
      end
    end
    m_count++;
    chk("flags_after", dut.w_flags, m_flags);
  endtask

  initial begin
    logic [3:0] cmds [5];
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    rst_n = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    @(posedge clk); #1;
    chk("rst_irwrite",  IRWrite,  0);
    chk("rst_pcwrite",  PCWrite,  0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_memwrite", MemWrite, 0);
    @(posedge clk); #1;
    chk("rst_flags", dut.w_flags, 4'b0000);
    rst_n = 1'b1;

    // ADDS imm: sets Z
    run_instr(4'hE, 2'b00, 6'b101001, 4'd2, 4'b0100, -1);
    // BEQ with Z=1: taken
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);
    // ADDS reg clears Z
    run_instr(4'hE, 2'b00, 6'b001001, 4'd3, 4'b0000, -1);
    // BEQ with Z=0: not taken
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);
    // LDR
    run_instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000, -1);
    // LDR into PC
    run_instr(4'hE, 2'b01, 6'b011001, 4'hF, 4'b0000, -1);
    // CMP equal operands
    run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0110, -1);
    // Never-condition ADD: no writes
    run_instr(4'hF, 2'b00, 6'b001001, 4'd1, 4'b1111, -1);
    // Undefined opcode
    run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, -1);
    // STR with reset pulled in MEMWR (phase index 3)
    run_instr(4'hE, 2'b01, 6'b011000, 4'd4, 4'b0000, 3);
    // Subsequent fetch after abort
    run_instr(4'hE, 2'b01, 6'b011000, 4'd4, 4'b0000, -1);

    for (int k = 0; k < 80; k++) begin
      logic [3:0] c, cmd;
      logic [5:0] fn;
      c   = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      cmd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : cmds[$urandom_range(0, 4)];
      fn  = {1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1))};
      run_instr(c, 2'($urandom_range(0, 3)), fn, 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_multicycle_ctrl
`default_nettype wire
